// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int INSTR_BYTES = 4;
  localparam int WORD_W      = 32;

  // Widened to 33 bits so a target near 2^32 cannot wrap into range.
  function automatic logic is_legal_target(input logic [WORD_W-1:0] addr,
                                           input int unsigned       mem_bytes);
    logic [WORD_W:0] end_addr;
    end_addr = {1'b0, addr} + (WORD_W+1)'(INSTR_BYTES);
    return (addr[1:0] == 2'b00) && (end_addr <= (WORD_W+1)'(mem_bytes));
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Memory-side and decode-side signals of the fetch controller.
interface fetch_controller_if #(
  parameter int CNT_W = 16
);
  import fetch_pkg::*;

  logic              start;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr_in;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_target;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    input  start, instr_in, instr_ready, redirect_valid, redirect_target,
    output pc, instr_out, instr_pc, instr_valid, halted, fault, fetch_count
  );

  modport slave (
    output start, instr_in, instr_ready, redirect_valid, redirect_target,
    input  pc, instr_out, instr_pc, instr_valid, halted, fault, fetch_count
  );

endinterface

// File: rtl/fetch_controller.sv
// Program counter, output register and control FSM between a combinational
// instruction memory and the decode stage.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned PROG_END  = 24,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_out_q, instr_out_d;
  logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic fetch_opp;
  logic target_ok;

  assign fetch_opp = !valid_q || bus.instr_ready;
  assign target_ok = is_legal_target(bus.redirect_target, MEM_BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= WORD_W'(RESET_PC);
      instr_out_q <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end

      FETCH, HALT: begin
        // A redirect flushes the held word even when decode is taking it.
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          if (target_ok) begin
            pc_d    = bus.redirect_target;
            state_d = FETCH;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (state_q == FETCH) begin
          if (fetch_opp) begin
            if (pc_q == WORD_W'(PROG_END)) begin
              state_d = HALT;
              valid_d = 1'b0;
            end else begin
              instr_out_d = bus.instr_in;
              instr_pc_d  = pc_q;
              valid_d     = 1'b1;
              pc_d        = pc_q + WORD_W'(INSTR_BYTES);
              cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
          end
        end else if (valid_q && bus.instr_ready) begin
          valid_d = 1'b0;
        end
      end

      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == HALT) && !valid_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against a cycle-level
// reference model of the fetch rules over a byte-array memory.
module tb_fetch_controller;

  localparam int MEM_BYTES = 32;
  localparam int PROG_END  = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_controller_if #(.CNT_W(16)) bus ();

  fetch_controller #(
    .RESET_PC (0),
    .MEM_BYTES(MEM_BYTES),
    .PROG_END (PROG_END),
    .CNT_W    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  mem [MEM_BYTES];
  logic [31:0] golden [8];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    if (a > 32'(MEM_BYTES - 4)) return 32'h0;
    i = int'(a);
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  always_comb bus.instr_in = word_at(bus.pc);

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 waiting, 1 running, 2 ended, 3 dead.
  int          m_mode;
  logic [31:0] m_pc, m_out, m_ipc;
  logic        m_valid, m_fault;
  int          m_cnt;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_out = 0; m_ipc = 0;
    m_valid = 0; m_fault = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic st, input logic rdy, input logic rv,
                            input logic [31:0] rt);
    longint t;
    t = longint'(rt);
    if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 3) begin
      m_valid = 0;
    end else if (rv) begin
      m_valid = 0;
      if ((t % 4 == 0) && (t + 4 <= MEM_BYTES)) begin
        m_pc = rt; m_mode = 1;
      end else begin
        m_mode = 3; m_fault = 1;
      end
    end else if (m_mode == 2) begin
      if (rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      if (m_pc == 32'(PROG_END)) begin
        m_mode = 2; m_valid = 0;
      end else begin
        m_out = word_at(m_pc); m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 4;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    chk("instr_out", bus.instr_out, m_out);
    chk("instr_pc", bus.instr_pc, m_ipc);
    chk("halted", 32'(bus.halted), 32'(m_mode == 2 && !m_valid));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  task automatic cyc(input logic st, input logic rdy, input logic rv,
                     input logic [31:0] rt);
    bus.start = st; bus.instr_ready = rdy;
    bus.redirect_valid = rv; bus.redirect_target = rt;
    model_step(st, rdy, rv, rt);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    golden[0] = 32'h00011020; golden[1] = 32'h00853022;
    golden[2] = 32'h01095024; golden[3] = 32'h01285025;
    golden[4] = 32'h01660180; golden[5] = 32'h01A90282;
    golden[6] = 32'hDEADBEEF; golden[7] = 32'hCAFEF00D;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++)
        mem[w*4+b] = golden[w][31-8*b -: 8];
    bus.start = 0; bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_target = 0;

    // Reset state before any clock edge
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;

    // No fetch without start; redirects ignored while waiting
    cyc(0, 1, 1, 32'd8);
    cyc(0, 0, 0, 32'd0);

    // Straight-line program with decode always ready
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0);
      chk("seq_valid", 32'(bus.instr_valid), 32'd1);
      chk("seq_out", bus.instr_out, golden[i]);
      chk("seq_pc", bus.instr_pc, 32'(4*i));
    end
    cyc(0, 1, 0, 0);
    chk("end_halted", 32'(bus.halted), 32'd1);
    chk("end_count", 32'(bus.fetch_count), 32'd6);
    cyc(1, 1, 0, 0);

    // Backpressure after the first word
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("bp_out", bus.instr_out, 32'h00011020);
      chk("bp_pc", bus.pc, 32'd4);
      chk("bp_count", 32'(bus.fetch_count), 32'd1);
    end
    cyc(0, 1, 0, 0);
    chk("bp_release", bus.instr_out, 32'h00853022);

    // Redirect while instr_pc=4 is offered
    do_reset();
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 10 && !(m_valid && m_ipc == 32'd4); i++) cyc(0, 1, 0, 0);
    chk("rd_setup", bus.instr_pc, 32'd4);
    cyc(0, 1, 1, 32'd16);
    chk("rd_flush", 32'(bus.instr_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk("rd_out", bus.instr_out, 32'h01660180);
    chk("rd_pc", bus.instr_pc, 32'd16);
    chk("rd_count", 32'(bus.fetch_count), 32'd3);

    // Halt, then redirect back into the program
    for (int i = 0; i < 10 && !bus.halted; i++) cyc(0, 1, 0, 0);
    chk("h_halted", 32'(bus.halted), 32'd1);
    cyc(0, 1, 1, 32'd8);
    chk("h_leave", 32'(bus.halted), 32'd0);
    cyc(0, 1, 0, 0);
    chk("h_out8", bus.instr_out, 32'h01095024);
    cyc(0, 1, 0, 0);
    chk("h_out12", bus.instr_out, 32'h01285025);
    for (int i = 0; i < 10 && !bus.halted; i++) cyc(0, 1, 0, 0);
    chk("h_rehalt", 32'(bus.halted), 32'd1);

    // Illegal targets: misaligned, then one past the memory
    for (int k = 0; k < 2; k++) begin
      do_reset();
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, (k == 0) ? 32'h6 : 32'd32);
      chk("flt_fault", 32'(bus.fault), 32'd1);
      for (int i = 0; i < 6; i++)
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 32'd4);
      chk("flt_valid", 32'(bus.instr_valid), 32'd0);
    end

    // Randomized traffic with legal redirects and occasional resets
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc(1'($urandom_range(0, 15) == 0 || m_mode == 0 && $urandom_range(0, 1) == 1),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 9) == 0),
          32'(4 * $urandom_range(0, PROG_END / 4)));
    end

    // Asynchronous reset between edges mid-stream
    do_reset();
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar_valid", 32'(bus.instr_valid), 32'd0);
    chk("ar_out", bus.instr_out, 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("ar_nofetch", 32'(bus.fetch_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
